// File: rtl/dino_jump_physics.sv
// Vertical jump physics for the dino runner game.
//
// A free-running divider (gated by enable) produces a physics step every
// UPDATE_DIV cycles. On each step the dino either launches (when a jump is
// pending while on the ground) or integrates height += velocity and then
// velocity -= GRAVITY, clamping height at MAX_HEIGHT and snapping to ground
// when the new height would be at or below zero.
//
// Optional feature: define DINO_JUMP_BUFFER_EN to buffer a jump request made
// while airborne; the dino relaunches on the first ground step after landing.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     run (1) / pause (0); pause freezes divider and physics
//   clear      synchronous return-to-ground, highest priority
//   jump_req   single-cycle jump request
//   height     unsigned height above ground
//   velocity   two's-complement vertical velocity
//   jumping    high while airborne
//   land_pulse one-cycle pulse on the landing step
//   step       one-cycle pulse on every physics step
module dino_jump_physics #(
  parameter int unsigned UPDATE_DIV = 1000000,
  parameter logic [15:0] JUMP_VEL   = 16'd20,
  parameter logic [15:0] GRAVITY    = 16'd2,
  parameter logic [15:0] MAX_HEIGHT = 16'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  input  logic        jump_req,
  output logic [15:0] height,
  output logic [15:0] velocity,
  output logic        jumping,
  output logic        land_pulse,
  output logic        step
);

  localparam int unsigned CntW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(UPDATE_DIV - 1);

`ifdef DINO_JUMP_BUFFER_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    StGround,
    StRise,
    StFall
  } state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [15:0]        height_q;
  logic [15:0]        velocity_q;
  logic               pending_q;
  logic               step_q;
  logic               land_q;

  logic               step_now;
  logic               jump_ok;
  logic signed [16:0] next_h;
  logic [15:0]        vel_dec;
  logic               land_now;
  logic [15:0]        clamp_h;
  logic               vel_pos;

  always_comb begin
    step_now = enable && (cnt_q == CntMax);
    // Airborne requests only count when buffering is built in.
    jump_ok  = enable && jump_req && ((state_q == StGround) || BufEn);
    next_h   = $signed({1'b0, height_q}) + $signed({velocity_q[15], velocity_q});
    vel_dec  = velocity_q - GRAVITY;
    land_now = next_h[16] || (next_h == 17'sd0);
    clamp_h  = (next_h > $signed({1'b0, MAX_HEIGHT})) ? MAX_HEIGHT : next_h[15:0];
    vel_pos  = !vel_dec[15] && (vel_dec != 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StGround;
      cnt_q      <= '0;
      height_q   <= '0;
      velocity_q <= '0;
      pending_q  <= 1'b0;
      step_q     <= 1'b0;
      land_q     <= 1'b0;
    end else if (clear) begin
      state_q    <= StGround;
      cnt_q      <= '0;
      height_q   <= '0;
      velocity_q <= '0;
      pending_q  <= 1'b0;
      step_q     <= 1'b0;
      land_q     <= 1'b0;
    end else begin
      step_q <= step_now;
      land_q <= 1'b0;
      if (enable) begin
        cnt_q <= step_now ? '0 : cnt_q + 1'b1;
      end
      if (jump_ok) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        StGround: begin
          // A request arriving on the step cycle itself launches on that step.
          if (step_now && (pending_q || jump_ok)) begin
            height_q   <= '0;
            velocity_q <= JUMP_VEL;
            pending_q  <= 1'b0;
            state_q    <= StRise;
          end
        end
        StRise, StFall: begin
          if (step_now) begin
            if (land_now) begin
              height_q   <= '0;
              velocity_q <= '0;
              land_q     <= 1'b1;
              state_q    <= StGround;
            end else begin
              // Clamp only the height; velocity keeps integrating so the
              // descent timing is unchanged by the ceiling.
              height_q   <= clamp_h;
              velocity_q <= vel_dec;
              state_q    <= vel_pos ? StRise : StFall;
            end
          end
        end
        default: state_q <= StGround;
      endcase
    end
  end

  assign height     = height_q;
  assign velocity   = velocity_q;
  assign jumping    = (state_q != StGround);
  assign land_pulse = land_q;
  assign step       = step_q;

endmodule

// File: doc/dino_jump_physics.md
DINO_JUMP_PHYSICS -- requirements
Module: dino_jump_physics

Interface
REQ-001 Parameter UPDATE_DIV, default 1000000, meaning Clock cycles per physics step (legal values 2 or more).
REQ-002 Parameter JUMP_VEL, default 16'd20, meaning launch velocity in height units per step.
REQ-003 Parameter GRAVITY, default 16'd2, meaning velocity decrement per airborne step.
REQ-004 Parameter MAX_HEIGHT, default 16'd100, meaning ceiling clamp for height.
REQ-005 Clock  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  high while the game is running; low freezes the block (pause).
REQ-008 clear  input  1  synchronous return-to-ground (new game).
REQ-009 jump_req  input  1  single-cycle jump request from the keyboard decoder.
REQ-010 height  output  16  unsigned dino height above ground, consumed by the VGA renderer.
REQ-011 velocity  output  16  two's-complement vertical velocity.
REQ-012 jumping  output  1  high while state is not GROUND.
REQ-013 land_pulse  output  1  one-cycle pulse on the step that returns to ground.
REQ-014 step  output  1  one-cycle pulse on every physics step; the scorekeeper uses it as a tick.

Function
REQ-015 Divider: counts 0..UPDATE_DIV-1 while enable=1 and issues step when the count wraps; the count holds while enable=0.
REQ-016 States: GROUND, RISE, FALL; state changes only on step cycles, except on clear.
REQ-017 jump_req with enable=1 in GROUND sets a pending flag; jump_req in RISE or FALL is dropped (see REQ-028); jump_req with enable=0 is ignored.
REQ-018 GROUND with step and pending: velocity<=JUMP_VEL, height<=0, pending<=0, and the next state is RISE.
REQ-019 Airborne step: next_h = height + velocity, computed signed in 17 bits.
REQ-020 If next_h <= 0: height<=0, velocity<=0, next state GROUND, land_pulse=1.
REQ-021 Otherwise: height<=min(next_h, MAX_HEIGHT), velocity<=velocity-GRAVITY.
REQ-022 After an airborne step, the state is RISE if the new velocity is >0 and FALL otherwise.
REQ-023 If jump_req and step occur in the same cycle in GROUND, the launch happens on that step.
REQ-024 clear has priority over step and jump_req; it forces GROUND, height=0, velocity=0, clears pending and the divider, and leaves all pulse outputs low.
REQ-025 Outputs are registered; height and velocity update in the cycle after the step edge.

Reset
REQ-026 While reset=0: state=GROUND, height=0, velocity=0, pending=0, divider=0, and jumping, land_pulse and step are all 0.
REQ-027 Reset asserted mid-jump aborts the jump immediately without a land_pulse; the next step after release occurs UPDATE_DIV cycles later.

Configuration
REQ-028 Macro DINO_JUMP_BUFFER_EN defined: jump_req while airborne sets pending, and the launch occurs on the first GROUND step after landing (land_pulse still fires). Macro undefined: airborne jump_req is discarded and pending is never set while airborne.

Verification
All scenarios use UPDATE_DIV=4, JUMP_VEL=10, GRAVITY=2, MAX_HEIGHT=100.
REQ-029 Jump from ground:
- Stimulus: enable=1, one jump_req.
- Response: height per step = 0,10,18,24,28,30,30,28,24,18,10,0.
- land_pulse fires exactly once, on the final step.
- jumping is high from the launch step until landing.
REQ-030 Pause:
- Stimulus: enable=0 for 20 cycles at height 24.
- Response: height stays 24, no step pulses occur, and the divider count is preserved.
- After enable returns, the next height is 28 after the remaining divider cycles.
REQ-031 Ceiling clamp:
- Stimulus: MAX_HEIGHT=25, one jump.
- Response: heights 0,10,18,24,25,25,...; velocity continues decrementing, so the clamp does not affect the descent timing.
REQ-032 clear mid-air:
- Stimulus: clear at height 28.
- Response: next cycle height=0, velocity=0, jumping=0, no land_pulse.
REQ-033 Async reset:
- Stimulus: reset low for 3 cycles mid-jump, asserted between clock edges.
- Response: outputs are 0 immediately, without waiting for an edge.
REQ-034 Jump buffering:
- Stimulus: jump_req at height 10 on the descent.
- Response with DINO_JUMP_BUFFER_EN: land_pulse, then on the next step velocity=10 and RISE.
- Response without the macro: the block stays in GROUND.
